// File: rtl/mem_responder.sv
// Memory responder: four small storage planes behind a delayed request/response port, plus a timestep counter.
// Latency: a request accepted at edge N completes at edge N+MEM_DELAY; read data is valid right after that edge.
// Backpressure: one request in flight; req_ready only in IDLE, read response held in RESP until rsp_ready.
// Optional feature: define MEM_RESPONDER_BOUNDS_CHECK_EN for out-of-range x/y detection (default: modulo wrap).
module mem_responder #(
    parameter int MEM_DELAY = 15,
    parameter int TIMESTEPS = 10,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [1:0]       req_sel,
    input  logic [2:0]       req_x,
    input  logic [2:0]       req_y,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             t_valid,
    output logic             t_ready,
    input  logic [3:0]       t_value,
    output logic [3:0]       cur_t,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SEL_MEMPOT = 2'd0;
    localparam logic [1:0] SEL_IFMAP  = 2'd1;
    localparam logic [1:0] SEL_FILTER = 2'd2;
    localparam logic [1:0] SEL_OFMAP  = 2'd3;

    // The counter is loaded on accept and completion fires when it reads zero,
    // so loading MEM_DELAY-1 lands completion exactly MEM_DELAY edges later.
    localparam logic [7:0] DELAY_LOAD = 8'(MEM_DELAY - 1);
    localparam logic [3:0] T_LAST     = 4'(TIMESTEPS);

    // x mod 3 for a 3-bit coordinate
    function automatic logic [1:0] mod3(input logic [2:0] v);
        logic [1:0] r;
        case (v)
            3'd0, 3'd3, 3'd6: r = 2'd0;
            3'd1, 3'd4, 3'd7: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

    // x mod 5 for a 3-bit coordinate
    function automatic logic [2:0] mod5(input logic [2:0] v);
        return (v > 3'd4) ? (v - 3'd5) : v;
    endfunction

    logic [1:0]       state;
    logic [7:0]       cnt;
    logic             op_q;
    logic [1:0]       sel_q;
    logic [2:0]       x_q;
    logic [2:0]       y_q;
    logic [WIDTH-1:0] wdata_q;

    // Storage planes: 3x3 multi-bit planes as arrays, 1-bit planes packed, index = y*dim + x.
    logic [WIDTH-1:0] mempot [0:8];
    logic [WIDTH-1:0] filter [0:8];
    logic [24:0]      ifmap;
    logic [8:0]       ofmap;

    logic [1:0]       x3;
    logic [1:0]       y3;
    logic [2:0]       x5;
    logic [2:0]       y5;
    logic             addr_ok;
    logic [3:0]       idx9;
    logic [4:0]       idx25;
    logic [WIDTH-1:0] rd_val;

    logic             complete;
    logic             commit;
    logic             t_fire;
    logic             t_advance;

    assign req_ready = (state == S_IDLE);
    // A pending request always takes priority over a timestep close.
    assign t_ready   = (state == S_IDLE) && !req_valid;

    assign complete  = (state == S_BUSY) && (cnt == 8'd0);
    assign commit    = complete && op_q && addr_ok;
    assign t_fire    = t_valid && t_ready;
    assign t_advance = t_fire && !done && (cur_t < T_LAST);

    // Address decode of the latched request: wrap or range-check, then flatten to a plane index.
    always_comb begin
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        x3 = x_q[1:0];
        y3 = y_q[1:0];
        x5 = x_q;
        y5 = y_q;
        if (sel_q == SEL_IFMAP) begin
            addr_ok = (x_q <= 3'd4) && (y_q <= 3'd4);
        end else begin
            addr_ok = (x_q <= 3'd2) && (y_q <= 3'd2);
        end
`else
        x3      = mod3(x_q);
        y3      = mod3(y_q);
        x5      = mod5(x_q);
        y5      = mod5(y_q);
        addr_ok = 1'b1;
`endif
        idx9  = ({2'b00, y3} * 4'd3) + {2'b00, x3};
        idx25 = ({2'b00, y5} * 5'd5) + {2'b00, x5};
    end

    // Read mux; 1-bit planes are zero-extended and out-of-range reads return zero.
    always_comb begin
        rd_val = '0;
        if (addr_ok) begin
            case (sel_q)
                SEL_MEMPOT: rd_val    = mempot[idx9];
                SEL_FILTER: rd_val    = filter[idx9];
                SEL_IFMAP:  rd_val[0] = ifmap[idx25];
                default:    rd_val[0] = ofmap[idx9];
            endcase
        end
    end

    // Request FSM: accept in IDLE, count down in BUSY, hold the read result in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            op_q      <= 1'b0;
            sel_q     <= 2'd0;
            x_q       <= 3'd0;
            y_q       <= 3'd0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        sel_q   <= req_sel;
                        x_q     <= req_x;
                        y_q     <= req_y;
                        wdata_q <= req_wdata;
                        cnt     <= DELAY_LOAD;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == 8'd0) begin
                        if (op_q) begin
                            state <= S_IDLE;
                        end else begin
                            rsp_data  <= rd_val;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Timestep tracking: advance cur_t up to TIMESTEPS, then latch done until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_t <= 4'd1;
            done  <= 1'b0;
        end else if (t_fire && !done) begin
            if (cur_t < T_LAST) begin
                cur_t <= cur_t + 4'd1;
            end else begin
                done <= 1'b1;
            end
        end
    end

    // Single-cycle error pulse: bad address at completion, or a timestep close that is out of order or after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (complete && !addr_ok) ||
                   (t_fire && (done || (t_value != cur_t)));
        end
    end

    // Plane storage: write commit at completion, ofmap cleared whenever a timestep advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                mempot[i] <= '0;
                filter[i] <= '0;
            end
            ifmap <= '0;
            ofmap <= '0;
        end else begin
            if (commit) begin
                case (sel_q)
                    SEL_MEMPOT: mempot[idx9] <= wdata_q;
                    SEL_FILTER: filter[idx9] <= wdata_q;
                    SEL_IFMAP:  ifmap[idx25] <= wdata_q[0];
                    default:    ofmap[idx9]  <= wdata_q[0];
                endcase
            end
            if (t_advance) begin
                ofmap <= '0;
            end
        end
    end

endmodule
